// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 16550-class serial transmitter. A byte-wide TX FIFO feeds a framing FSM that
// sends start, 5-8 data bits (LSB first), optional parity and 1/1.5/2 stop bits, each bit
// lasting OVERSAMPLE baud_tick pulses. The frame format is latched from lcr when a byte is popped.
// Optional feature: define UART_TX_BREAK_EN so that the live lcr[6] forces stx low (break).
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            baud_tick,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    input  logic [7:0]      lcr,
    input  logic            fifo_clr,
    output logic            stx,
    output logic            thr_empty,
    output logic            temt,
    output logic            fifo_full,
    output logic [ADDR_W:0] fifo_level,
    output logic            overflow,
    output logic            tx_done
);
    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(2 * OVERSAMPLE + 1);

    localparam logic [LVL_W-1:0]  LVL_FULL      = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE       = LVL_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE       = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LEN_BIT_M1    = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  LEN_STOP15_M1 = CNT_W'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  LEN_STOP2_M1  = CNT_W'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // FIFO state
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q;
    logic              empty, full, push, pop;

    // Framing state
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        wlen_q, wlen_d;
    logic              stop2_q, stop2_d;
    logic              pen_q, pen_d;
    logic              par_q, par_d;
    logic              stx_q, stx_d;
    logic              done_q, done_d;
    logic              fsm_stx;
    logic [CNT_W-1:0]  len_m1;
    logic              bit_end;
    logic              unused_lcr;

    assign unused_lcr = ^lcr[7:6];

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    // A full FIFO still accepts a write when the FSM pops in the same cycle
    assign push  = wr_en && (!full || pop);

    // Parity over the wlen data bits only; stick parity ignores the data
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wlen,
                                         input logic eps, input logic stick);
        logic [7:0] masked;
        case (wlen)
            2'd0:    masked = {3'b000, data[4:0]};
            2'd1:    masked = {2'b00, data[5:0]};
            2'd2:    masked = {1'b0, data[6:0]};
            default: masked = data;
        endcase
        if (stick) return ~eps;
        return eps ? ^masked : ~^masked;
    endfunction

    // FIFO pointers, level and overflow pulse; fifo_clr keeps a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (fifo_clr) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= wr_en ? PTR_ONE : '0;
            level_q    <= wr_en ? LVL_ONE : '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_q <= level_q + LVL_ONE;
            else if (!push && pop) level_q <= level_q - LVL_ONE;
            overflow_q <= wr_en && !push;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (fifo_clr && wr_en) begin
            mem_q[0] <= wr_data;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Length of the current bit minus one, in ticks
    always_comb begin
        len_m1 = LEN_BIT_M1;
        if (state_q == StStop && stop2_q) begin
            len_m1 = (wlen_q == 2'd0) ? LEN_STOP15_M1 : LEN_STOP2_M1;
        end
    end

    assign bit_end = baud_tick && (tick_q == len_m1);

    // Framing FSM next state, FIFO pop and serial bit selection
    always_comb begin
        state_d = state_q;
        tick_d  = baud_tick ? tick_q + CNT_ONE : tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wlen_d  = wlen_q;
        stop2_d = stop2_q;
        pen_d   = pen_q;
        par_d   = par_q;
        pop     = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                tick_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    tick_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    // Last data bit index is wlen-1 = 4 + wlen code
                    if (bit_q == {1'b1, wlen_q}) begin
                        state_d = pen_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tick_d  = '0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    tick_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase

        // Popping loads the head byte and freezes the frame format for this frame
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            wlen_d  = lcr[1:0];
            stop2_d = lcr[2];
            pen_d   = lcr[3];
            par_d   = calc_parity(mem_q[rd_ptr_q], lcr[1:0], lcr[4], lcr[5]);
        end

        case (state_d)
            StStart:  fsm_stx = 1'b0;
            StData:   fsm_stx = shift_d[0];
            StParity: fsm_stx = par_d;
            default:  fsm_stx = 1'b1;
        endcase

`ifdef UART_TX_BREAK_EN
        stx_d = lcr[6] ? 1'b0 : fsm_stx;
`else
        stx_d = fsm_stx;
`endif
    end

    // Framing state registers; stx is registered so it tracks the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wlen_q  <= '0;
            stop2_q <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            stx_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wlen_q  <= wlen_d;
            stop2_q <= stop2_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            stx_q   <= stx_d;
            done_q  <= done_d;
        end
    end

    assign stx        = stx_q;
    assign thr_empty  = empty;
    assign temt       = empty && (state_q == StIdle);
    assign fifo_full  = full;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo (FIFO_DEPTH=16, OVERSAMPLE=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst, baud_tick, wr_en, fifo_clr;
    logic [7:0] wr_data, lcr;
    logic       stx, thr_empty, temt, fifo_full, overflow, tx_done;
    logic [4:0] fifo_level;

    int vectors = 0;
    int miscompares = 0;
    int n, nd, no;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .FIFO_DEPTH(16),
        .ADDR_W    (4),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .lcr       (lcr),
        .fifo_clr  (fifo_clr),
        .stx       (stx),
        .thr_empty (thr_empty),
        .temt      (temt),
        .fifo_full (fifo_full),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .tx_done   (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // stx must hold v for the next 'cycles' falling edges
    task automatic expect_level(input logic v, input int cycles, input string tag);
        repeat (cycles) begin
            @(negedge clk);
            chk(tag, stx, v);
        end
    endtask

    // Full frame check with baud_tick held high (16 clocks per bit), then the done cycle
    task automatic expect_frame(input logic [7:0] d, input int nbits, input bit has_par,
                                input logic par, input int stop_cycles, input int start_cycles);
        expect_level(1'b0, start_cycles, "start_bit");
        for (int i = 0; i < nbits; i++) expect_level(d[i], 16, "data_bit");
        if (has_par) expect_level(par, 16, "parity_bit");
        expect_level(1'b1, stop_cycles, "stop_bit");
        @(negedge clk);
        chk("tx_done_pulse", tx_done, 1'b1);
        chk("temt_after", temt, 1'b1);
        chk("thr_empty_after", thr_empty, 1'b1);
        chk("stx_idle", stx, 1'b1);
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_temt(input int bound, output int cnt, output int dones, output int ovfs);
        cnt = 0;
        dones = 0;
        ovfs = 0;
        while (cnt < bound) begin
            @(negedge clk);
            cnt++;
            if (tx_done) dones++;
            if (overflow) ovfs++;
            if (temt) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        baud_tick = 1'b0;
        wr_en = 1'b0;
        fifo_clr = 1'b0;
        wr_data = 8'h00;
        lcr = 8'h03;
        repeat (3) @(negedge clk);
        chk("rst_stx", stx, 1'b1);
        chk("rst_thr_empty", thr_empty, 1'b1);
        chk("rst_temt", temt, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_level", fifo_level, 5'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        rst = 1'b0;
        baud_tick = 1'b1;

        // 8N1 0x55; lcr changed after the frame started must not affect it
        lcr = 8'h03;
        write_byte(8'h55);
        chk("lvl_after_write", fifo_level, 5'd1);
        chk("temt_busy", temt, 1'b0);
        expect_level(1'b0, 1, "start_bit");
        lcr = 8'h00;
        expect_frame(8'h55, 8, 1'b0, 1'b0, 16, 15);
        @(negedge clk);
        chk("tx_done_single", tx_done, 1'b0);

        // Bit timing only advances on baud_tick
        lcr = 8'h03;
        baud_tick = 1'b0;
        write_byte(8'hFF);
        expect_level(1'b0, 40, "start_no_tick");
        baud_tick = 1'b1;
        expect_frame(8'hFF, 8, 1'b0, 1'b0, 16, 15);

        // Parity: 0xA7 has 5 ones -> even parity bit 1; 0x03 -> 0
        lcr = 8'h1B;
        write_byte(8'hA7);
        expect_frame(8'hA7, 8, 1'b1, 1'b1, 16, 16);
        write_byte(8'h03);
        expect_frame(8'h03, 8, 1'b1, 1'b0, 16, 16);
        // 7-bit odd parity: bit 7 excluded, 2 ones -> parity 1
        lcr = 8'h0A;
        write_byte(8'h83);
        expect_frame(8'h83, 7, 1'b1, 1'b1, 16, 16);
        // Stick parity with EPS=0 -> parity bit 1 regardless of data
        lcr = 8'h2B;
        write_byte(8'h00);
        expect_frame(8'h00, 8, 1'b1, 1'b1, 16, 16);
        write_byte(8'hFF);
        expect_frame(8'hFF, 8, 1'b1, 1'b1, 16, 16);

        // Stop lengths: 5-bit with 1.5 stop, 8-bit with 2 stop
        lcr = 8'h04;
        write_byte(8'h1F);
        expect_frame(8'h1F, 5, 1'b0, 1'b0, 24, 16);
        lcr = 8'h07;
        write_byte(8'h1F);
        expect_frame(8'h1F, 8, 1'b0, 1'b0, 32, 16);

        // Break bit
        lcr = 8'h43;
        write_byte(8'h55);
`ifdef UART_TX_BREAK_EN
        expect_level(1'b0, 160, "break_low");
        lcr = 8'h03;
        @(negedge clk);
        chk("break_tx_done", tx_done, 1'b1);
        chk("break_temt", temt, 1'b1);
        chk("break_release", stx, 1'b1);
`else
        expect_frame(8'h55, 8, 1'b0, 1'b0, 16, 16);
`endif

        // 18 writes back to back: 1 popped, 16 stored, last one dropped
        lcr = 8'h03;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 17) begin
                chk("burst_level16", fifo_level, 5'd16);
                chk("burst_full", fifo_full, 1'b1);
                chk("burst_no_ovf_17", overflow, 1'b0);
            end
            wr_en   = 1'b1;
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("burst_ovf_pulse", overflow, 1'b1);
        chk("burst_level_kept", fifo_level, 5'd16);
        wait_temt(4000, n, nd, no);
        // 17 frames x 160 clocks with no idle gap
        chk("burst_duration", n, 32'd2704);
        chk("burst_done_count", nd, 32'd17);
        chk("burst_extra_ovf", no, 32'd0);

        // fifo_clr mid-frame: current frame completes; clr+write keeps that byte
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'h55 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("clr_pre_level", fifo_level, 5'd2);
        @(negedge clk);
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        chk("clr_level", fifo_level, 5'd0);
        chk("clr_thr_empty", thr_empty, 1'b1);
        chk("clr_temt_busy", temt, 1'b0);
        chk("clr_frame_alive", stx, 1'b0);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h11;
        @(negedge clk);
        fifo_clr = 1'b1;
        wr_data  = 8'h22;
        @(negedge clk);
        fifo_clr = 1'b0;
        wr_en    = 1'b0;
        chk("clr_wr_level", fifo_level, 5'd1);
        wait_temt(1000, n, nd, no);
        chk("clr_duration", n, 32'd313);
        chk("clr_done_count", nd, 32'd2);

        // Reset in the middle of a data bit
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'h55;
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (37) @(negedge clk);
        chk("pre_rst_data0", stx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_stx", stx, 1'b1);
        chk("mid_rst_level", fifo_level, 5'd0);
        chk("mid_rst_temt", temt, 1'b1);
        chk("mid_rst_thr_empty", thr_empty, 1'b1);
        nd = 0;
        no = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_done) nd++;
            if (!stx) no++;
        end
        chk("post_rst_no_done", nd, 32'd0);
        chk("post_rst_stx_idle", no, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
